mult_share_arbiter: RTL
=======================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 40, maximum WAIT cycles allowed for mul_rdy before the operation is aborted.
REQ-002 Parameter: W, 32, operand width; result width is 2*W.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-low.
REQ-005 req_a / req_b  input  1  requester A/B wants one multiply; held high until its done pulse.
REQ-006 a_mcand, a_mplier / b_mcand, b_mplier  input  W  operands; stable while req is high.
REQ-007 gnt_a / gnt_b  output  1  high from LOAD through DONE for the owning requester.
REQ-008 done_a / done_b  output  1  one-cycle completion pulse to the owner.
REQ-009 result  output  2W  product, valid only while done_a or done_b is high, else 0.
REQ-010 err  output  1  one-cycle pulse coincident with done_x when the operation timed out.
REQ-011 mul_mult, mul_mul  output  W  operands to the shared multiplier, held from LOAD through WAIT.
REQ-012 mul_load  output  1  one-cycle load/clear pulse to the multiplier.
REQ-013 mul_run  output  1  one-cycle start pulse to the multiplier.
REQ-014 mul_prod  input  2W  multiplier product; mul_rdy  input  1  multiplier completion flag.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, WAIT, DONE; exactly one request in flight.
REQ-016 IDLE: if any req is high at the edge, pick an owner, latch its operands into mul_mult/mul_mul and the owner id, go to LOAD; else stay.
REQ-017 Arbitration SHALL be round-robin: with both requesting, the requester not served last wins; after reset A has priority.
REQ-018 LOAD: mul_load=1 for exactly one cycle, then RUN.
REQ-019 RUN: mul_run=1 for exactly one cycle, then WAIT; watchdog counter cleared to 0.
REQ-020 mul_rdy SHALL be ignored in IDLE, LOAD and RUN (stale flag from previous op).
REQ-021 WAIT: on mul_rdy=1, capture mul_prod into the result register, go to DONE with err=0.
REQ-022 WAIT: counter increments each cycle without mul_rdy; on reaching TIMEOUT, result register := 0, set err, go to DONE.
REQ-023 DONE: one cycle; done_x and result (and err if timed out) asserted for the owner only; then IDLE.
REQ-024 Latency: req sampled in IDLE at edge N -> LOAD cycle N+1, RUN N+2, WAIT from N+3; done_x in the cycle after mul_rdy is sampled high.
REQ-025 A requester holding req through its own done pulse is treated as a new request; the other requester, if pending, wins first.
REQ-026 Changes of req or operands outside IDLE SHALL NOT affect the operation in flight.
REQ-027 gnt_a and gnt_b SHALL never be high together; done_a and done_b SHALL never be high together.

Reset
REQ-028 Rst low at an edge SHALL force IDLE, clear counter, owner and result registers, and set the round-robin pointer to favour A.
REQ-029 While and after reset all outputs SHALL be 0 (gnt, done, err, result, mul_mult, mul_mul, mul_load, mul_run).
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse; the next request starts a fresh LOAD.

Structure
REQ-031 Shared package mult_arb_pkg SHALL hold the state enum, W, TIMEOUT default and the owner-id type.
REQ-032 The two-way round-robin selection SHALL be a sub-module mult_rr_pick (inputs req_a, req_b, last owner; output winner, valid).

Verification
REQ-033 A only, 3 x 5, multiplier model rdy 33 cycles after run -> gnt_a from LOAD, done_a single pulse, result 15, err 0, gnt_b never high.
REQ-034 A and B raised same cycle after reset, A 0xFFFFFFFF x 0xFFFFFFFF, B 7 x 6 -> A served first with 0xFFFFFFFE00000001, then B with 42.
REQ-035 Both hold req for 4 operations -> owners strictly A, B, A, B; no cycle with both gnt high.
REQ-036 Model never asserts rdy, TIMEOUT=40 -> done_a and err pulse together 40 WAIT cycles after RUN, result 0, FSM back to IDLE.
REQ-037 Model holds mul_rdy high from prior op through LOAD/RUN -> no early completion; done only after rdy is re-sampled in WAIT.
REQ-038 Rst low for one cycle in WAIT -> all outputs 0 next cycle, no done pulse; subsequent B request 2 x 9 returns 18.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
package mult_arb_pkg;

    localparam int MULT_W       = 32;
    localparam int MULT_TIMEOUT = 40;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/mult_rr_pick.sv
// Two-way round-robin pick: with both requesting, the one not served last wins.
module mult_rr_pick
    import mult_arb_pkg::*;
(
    input  logic   i_req_a,
    input  logic   i_req_b,
    input  owner_t i_last,
    output owner_t o_winner,
    output logic   o_valid
);

    always_comb begin
        o_valid  = i_req_a | i_req_b;
        o_winner = OWN_A;
        if (i_req_a && i_req_b) begin
            o_winner = (i_last == OWN_A) ? OWN_B : OWN_A;
        end else if (i_req_b) begin
            o_winner = OWN_B;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multi-cycle multiplier between requesters A and B, with a
// watchdog that aborts an operation whose multiplier never reports ready.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int W       = MULT_W,
    parameter int TIMEOUT = MULT_TIMEOUT
)(
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_req_a,
    input  logic           i_req_b,
    input  logic [W-1:0]   i_a_mcand,
    input  logic [W-1:0]   i_a_mplier,
    input  logic [W-1:0]   i_b_mcand,
    input  logic [W-1:0]   i_b_mplier,
    output logic           o_gnt_a,
    output logic           o_gnt_b,
    output logic           o_done_a,
    output logic           o_done_b,
    output logic [2*W-1:0] o_result,
    output logic           o_err,
    output logic [W-1:0]   o_mul_mult,
    output logic [W-1:0]   o_mul_mul,
    output logic           o_mul_load,
    output logic           o_mul_run,
    input  logic [2*W-1:0] i_mul_prod,
    input  logic           i_mul_rdy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         r_state;
    owner_t         r_owner;
    owner_t         r_last;
    logic [CW-1:0]  r_cnt;
    logic           r_gnt_a;
    logic           r_gnt_b;
    logic           r_done_a;
    logic           r_done_b;
    logic           r_err;
    logic [2*W-1:0] r_result;
    logic [W-1:0]   r_mul_mult;
    logic [W-1:0]   r_mul_mul;
    logic           r_mul_load;
    logic           r_mul_run;

    owner_t         w_winner;
    logic           w_valid;

    mult_rr_pick u_pick (
        .i_req_a  (i_req_a),
        .i_req_b  (i_req_b),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Requests are only looked at in IDLE, so req/operand changes during an
    // operation never disturb it; mul_rdy is likewise only trusted in WAIT.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_A;
            r_last     <= OWN_B;
            r_cnt      <= '0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_done_a   <= 1'b0;
            r_done_b   <= 1'b0;
            r_err      <= 1'b0;
            r_result   <= '0;
            r_mul_mult <= '0;
            r_mul_mul  <= '0;
            r_mul_load <= 1'b0;
            r_mul_run  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner    <= w_winner;
                        r_last     <= w_winner;
                        r_mul_mult <= (w_winner == OWN_A) ? i_a_mcand  : i_b_mcand;
                        r_mul_mul  <= (w_winner == OWN_A) ? i_a_mplier : i_b_mplier;
                        r_gnt_a    <= (w_winner == OWN_A);
                        r_gnt_b    <= (w_winner == OWN_B);
                        r_mul_load <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_mul_load <= 1'b0;
                    r_mul_run  <= 1'b1;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    r_mul_run <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mul_rdy) begin
                        r_result <= i_mul_prod;
                        r_err    <= 1'b0;
                        r_done_a <= (r_owner == OWN_A);
                        r_done_b <= (r_owner == OWN_B);
                        r_state  <= ST_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // The last allowed WAIT cycle passed without ready: abort.
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_done_a <= (r_owner == OWN_A);
                        r_done_b <= (r_owner == OWN_B);
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done_a <= 1'b0;
                    r_done_b <= 1'b0;
                    r_err    <= 1'b0;
                    r_result <= '0;
                    r_gnt_a  <= 1'b0;
                    r_gnt_b  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt_a    = r_gnt_a;
    assign o_gnt_b    = r_gnt_b;
    assign o_done_a   = r_done_a;
    assign o_done_b   = r_done_b;
    assign o_err      = r_err;
    assign o_result   = r_result;
    assign o_mul_mult = r_mul_mult;
    assign o_mul_mul  = r_mul_mul;
    assign o_mul_load = r_mul_load;
    assign o_mul_run  = r_mul_run;

endmodule
